// File: rtl/uart_rx_sm.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_sm
// Description : 8N1 UART receiver with optional parity, internal baud timing,
//               data-ready flag and sticky framing/parity/overrun errors.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_sm #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 RX,
    input  logic                 RX_en,
    input  logic                 clear,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_ready,
    output logic                 framing_err,
    output logic                 parity_err,
    output logic                 overrun_err,
    output logic                 busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = $clog2(DATA_BITS + 1);

    localparam logic [CNT_W-1:0] c_half_tick = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] c_full_tick = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] c_last_bit  = BIT_W'(DATA_BITS - 1);
    localparam logic             c_par_odd   = (PARITY_ODD != 0);

    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_start  = 3'd1;
    localparam logic [2:0] c_st_data   = 3'd2;
    localparam logic [2:0] c_st_parity = 3'd3;
    localparam logic [2:0] c_st_stop   = 3'd4;

    logic                 r_sync1;
    logic                 r_rx_s;
    logic                 r_rx_prev;
    logic [2:0]           r_state;
    logic [CNT_W-1:0]     r_baud;
    logic [BIT_W-1:0]     r_bit;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par_pend;
    logic [DATA_BITS-1:0] r_rx_data;
    logic                 r_rx_valid;
    logic                 r_rx_ready;
    logic                 r_framing_err;
    logic                 r_parity_err;
    logic                 r_overrun_err;

    logic [2:0] w_next;
    logic       w_start_edge;
    logic       w_tick_half;
    logic       w_tick_full;
    logic       w_frame_start;
    logic       w_shift_en;
    logic       w_par_sample;
    logic       w_accept;
    logic       w_frame_bad;
    logic       w_busy;

    assign w_start_edge = ~r_rx_s & r_rx_prev;
    assign w_tick_half  = (r_baud == c_half_tick);
    assign w_tick_full  = (r_baud == c_full_tick);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; a dropped enable overrides every frame transition
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_st_idle:   if (RX_en && w_start_edge) w_next = c_st_start;
            c_st_start:  if (w_tick_half) w_next = r_rx_s ? c_st_idle : c_st_data;
            c_st_data:   if (w_tick_full && (r_bit == c_last_bit))
                             w_next = (PARITY_EN != 0) ? c_st_parity : c_st_stop;
            c_st_parity: if (w_tick_full) w_next = c_st_stop;
            c_st_stop:   if (w_tick_full) w_next = c_st_idle;
            default:     w_next = c_st_idle;
        endcase
        if (!RX_en && (r_state != c_st_idle)) w_next = c_st_idle;
    end

    // Output / datapath strobes
    always_comb begin
        w_busy        = (r_state != c_st_idle);
        w_frame_start = (r_state == c_st_idle) && (w_next == c_st_start);
        w_shift_en    = (r_state == c_st_data)   && w_tick_full && RX_en;
        w_par_sample  = (r_state == c_st_parity) && w_tick_full && RX_en;
        w_accept      = (r_state == c_st_stop)   && w_tick_full && RX_en && r_rx_s;
        w_frame_bad   = (r_state == c_st_stop)   && w_tick_full && RX_en && !r_rx_s;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1       <= 1'b1;
            r_rx_s        <= 1'b1;
            r_rx_prev     <= 1'b1;
            r_baud        <= '0;
            r_bit         <= '0;
            r_shift       <= '0;
            r_par_pend    <= 1'b0;
            r_rx_data     <= '0;
            r_rx_valid    <= 1'b0;
            r_rx_ready    <= 1'b0;
            r_framing_err <= 1'b0;
            r_parity_err  <= 1'b0;
            r_overrun_err <= 1'b0;
        end else begin
            r_sync1    <= RX;
            r_rx_s     <= r_sync1;
            r_rx_prev  <= r_rx_s;
            r_rx_valid <= 1'b0;

            if ((w_next != r_state) || w_tick_full) begin
                r_baud <= '0;
            end else if (w_busy) begin
                r_baud <= r_baud + CNT_W'(1);
            end

            if (w_frame_start) begin
                r_bit      <= '0;
                r_par_pend <= 1'b0;
            end
            if (w_shift_en) begin
                r_shift <= {r_rx_s, r_shift[DATA_BITS-1:1]};
                r_bit   <= r_bit + BIT_W'(1);
            end
            if (w_par_sample) begin
                r_par_pend <= (r_rx_s != ((^r_shift) ^ c_par_odd));
            end

            // A coincident clear wipes the old word's flags before the new frame's are applied
            if (w_accept) begin
                r_rx_data     <= r_shift;
                r_rx_valid    <= 1'b1;
                r_rx_ready    <= 1'b1;
                r_framing_err <= r_framing_err & ~clear;
                r_parity_err  <= (r_parity_err & ~clear) | r_par_pend;
                r_overrun_err <= (r_overrun_err | r_rx_ready) & ~clear;
            end else if (w_frame_bad) begin
                r_framing_err <= 1'b1;
                r_rx_ready    <= r_rx_ready & ~clear;
                r_parity_err  <= r_parity_err & ~clear;
                r_overrun_err <= r_overrun_err & ~clear;
            end else if (clear) begin
                r_rx_ready    <= 1'b0;
                r_framing_err <= 1'b0;
                r_parity_err  <= 1'b0;
                r_overrun_err <= 1'b0;
            end
        end
    end

    assign rx_data     = r_rx_data;
    assign rx_valid    = r_rx_valid;
    assign rx_ready    = r_rx_ready;
    assign framing_err = r_framing_err;
    assign parity_err  = r_parity_err;
    assign overrun_err = r_overrun_err;
    assign busy        = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_sm.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_sm
// Description : Self-checking bench for uart_rx_sm (no-parity and even-parity
//               instances) against a frame-level behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_sm;

    localparam int CPB = 16;
    localparam int DB  = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] rx;
    logic [1:0] en;
    logic [1:0] clr;
    logic [7:0] data [2];
    logic [1:0] valid, ready, fe, pe, oe, busy;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int vcnt  [2] = '{0, 0};
    int vcyc  [2] = '{0, 0};
    int vwide [2] = '{0, 0};
    logic [1:0] vprev = 2'b00;
    int t0 [2];

    logic [7:0] m_data  [2];
    bit         m_ready [2];
    bit         m_fe    [2];
    bit         m_pe    [2];
    bit         m_oe    [2];
    int         m_vcnt  [2] = '{0, 0};

    uart_rx_sm #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB), .PARITY_EN(0), .PARITY_ODD(0)) u_dut0 (
        .clk(clk), .rst(rst), .RX(rx[0]), .RX_en(en[0]), .clear(clr[0]),
        .rx_data(data[0]), .rx_valid(valid[0]), .rx_ready(ready[0]),
        .framing_err(fe[0]), .parity_err(pe[0]), .overrun_err(oe[0]), .busy(busy[0])
    );

    uart_rx_sm #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB), .PARITY_EN(1), .PARITY_ODD(0)) u_dut1 (
        .clk(clk), .rst(rst), .RX(rx[1]), .RX_en(en[1]), .clear(clr[1]),
        .rx_data(data[1]), .rx_valid(valid[1]), .rx_ready(ready[1]),
        .framing_err(fe[1]), .parity_err(pe[1]), .overrun_err(oe[1]), .busy(busy[1])
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every rx_valid pulse, its cycle, and any pulse longer than one cycle
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (valid[d]) begin
                vcnt[d] <= vcnt[d] + 1;
                vcyc[d] <= cyc;
                if (vprev[d]) vwide[d] <= vwide[d] + 1;
            end
            vprev[d] <= valid[d];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic reset_model();
        for (int d = 0; d < 2; d++) begin
            m_data[d]  = 8'h00;
            m_ready[d] = 1'b0;
            m_fe[d]    = 1'b0;
            m_pe[d]    = 1'b0;
            m_oe[d]    = 1'b0;
        end
    endtask

    // Even parity: data ones plus the parity bit must total an even number
    function automatic bit par_bad(input logic [7:0] w, input logic p);
        return ((($countones(w) + int'(p)) % 2) != 0);
    endfunction

    task automatic drive_bits(input int d, input logic b, input int n);
        rx[d] = b;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input int d, input logic [7:0] w, input logic p, input logic stop);
        int lat;
        t0[d] = cyc;
        drive_bits(d, 1'b0, CPB);
        for (int i = 0; i < DB; i++) drive_bits(d, w[i], CPB);
        if (d == 1) drive_bits(d, p, CPB);
        drive_bits(d, stop, CPB);
        rx[d] = 1'b1;
        if (stop) begin
            if (m_ready[d]) m_oe[d] = 1'b1;
            m_ready[d] = 1'b1;
            m_data[d]  = w;
            m_vcnt[d]++;
            if ((d == 1) && par_bad(w, p)) m_pe[d] = 1'b1;
            // stop sample after start edge, plus 2 synchroniser cycles and the registered pulse
            lat = (1 + DB + d) * CPB + CPB / 2 + 3;
            chk($sformatf("latency%0d", d), vcyc[d] - t0[d], lat);
        end else begin
            m_fe[d] = 1'b1;
        end
    endtask

    task automatic pulse_clear(input int d);
        clr[d] = 1'b1;
        idle(1);
        clr[d] = 1'b0;
        m_ready[d] = 1'b0;
        m_fe[d]    = 1'b0;
        m_pe[d]    = 1'b0;
        m_oe[d]    = 1'b0;
    endtask

    task automatic check_all(input int d);
        chk($sformatf("rx_data%0d", d),     data[d],  m_data[d]);
        chk($sformatf("rx_ready%0d", d),    ready[d], m_ready[d]);
        chk($sformatf("framing_err%0d", d), fe[d],    m_fe[d]);
        chk($sformatf("parity_err%0d", d),  pe[d],    m_pe[d]);
        chk($sformatf("overrun_err%0d", d), oe[d],    m_oe[d]);
        chk($sformatf("busy%0d", d),        busy[d],  1'b0);
        chk($sformatf("valid_count%0d", d), vcnt[d],  m_vcnt[d]);
    endtask

    initial begin
        int         d;
        logic [7:0] w;
        logic       p;
        logic       stop;

        rst = 1'b1;
        rx  = 2'b11;
        en  = 2'b11;
        clr = 2'b00;
        reset_model();
        idle(3);
        rst = 1'b0;
        idle(1);
        check_all(0);
        check_all(1);
        chk("valid_after_reset", {30'd0, valid}, 32'd0);

        // Bad stop bit: data and ready must stay at reset values
        send_frame(0, 8'h3C, 1'b0, 1'b0);
        check_all(0);
        pulse_clear(0);
        check_all(0);

        send_frame(0, 8'hA5, 1'b0, 1'b1);
        check_all(0);

        // Short low glitch on the line
        rx[0] = 1'b0;
        idle(4);
        chk("glitch_busy", busy[0], 1'b1);
        rx[0] = 1'b1;
        idle(20);
        check_all(0);

        // Back-to-back words without clear
        pulse_clear(0);
        send_frame(0, 8'h11, 1'b0, 1'b1);
        send_frame(0, 8'h22, 1'b0, 1'b1);
        check_all(0);
        pulse_clear(0);
        check_all(0);

        // Even parity: 0x07 has three ones, so the parity bit must be 1
        send_frame(1, 8'h07, 1'b0, 1'b1);
        check_all(1);
        pulse_clear(1);
        send_frame(1, 8'h07, 1'b1, 1'b1);
        check_all(1);

        // Enable dropped mid-frame
        drive_bits(0, 1'b0, CPB);
        for (int i = 0; i < 3; i++) drive_bits(0, 1'b1, CPB);
        en[0] = 1'b0;
        idle(1);
        chk("abort_busy", busy[0], 1'b0);
        idle(CPB * 7);
        check_all(0);
        en[0] = 1'b1;
        idle(2);

        // Reset mid-frame
        drive_bits(0, 1'b0, CPB);
        for (int i = 0; i < 3; i++) drive_bits(0, 1'b1, CPB);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        reset_model();
        check_all(0);
        check_all(1);
        drive_bits(0, 1'b1, 2 * CPB);
        send_frame(0, 8'h5A, 1'b0, 1'b1);
        check_all(0);

        // Randomised frames on both instances
        for (int k = 0; k < 40; k++) begin
            d    = int'($urandom_range(0, 1));
            w    = 8'($urandom);
            p    = 1'($urandom_range(0, 1));
            stop = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 2) == 0) pulse_clear(d);
            idle(int'($urandom_range(1, 10)));
            send_frame(d, w, p, stop);
            check_all(d);
        end

        idle(CPB);
        chk("valid_width0", vwide[0], 0);
        chk("valid_width1", vwide[1], 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
